// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler slice.
//   - Floor one-hot encodings (floor1 = bit0 .. floor3 = bit2)
//   - Bit positions on the atflr / flrsw buses
//   - Scheduler FSM state enum
//   - One-hot helper used to qualify controller floor reports
package elevator_pkg;

   localparam int unsigned NUM_FLOORS = 3;

   localparam logic [2:0] FLR_NONE = 3'b000;
   localparam logic [2:0] FLR1     = 3'b001;
   localparam logic [2:0] FLR2     = 3'b010;
   localparam logic [2:0] FLR3     = 3'b100;

   // atflr[3] = door open, flrsw[3] = door block; bits [2:0] carry the floor
   localparam int unsigned DOOR_BIT = 3;
   localparam int unsigned FLR_MSB  = 2;

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      DWELL
   } state_t;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == FLR1) || (v == FLR2) || (v == FLR3);
   endfunction

endpackage

// File: rtl/elevator_target_sel.sv
// Combinational target selector.
//   pending   : latched outstanding calls (one bit per floor)
//   cur_floor : one-hot current car floor
//   dir_up    : current sweep direction (1 = up)
//   target    : one-hot floor to serve next, 000 when nothing is pending
//   dir_flip  : 1 when the chosen floor lies against the current sweep
// Priority: a call at the current floor, then the nearest call ahead in the
// sweep direction, then the nearest call behind (which reverses the sweep).
module elevator_target_sel
   import elevator_pkg::*;
(
   input  logic [2:0] pending,
   input  logic [2:0] cur_floor,
   input  logic       dir_up,
   output logic [2:0] target,
   output logic       dir_flip
);

   logic [2:0] up_t;
   logic [2:0] dn_t;

   always_comb begin
      up_t     = FLR_NONE;
      dn_t     = FLR_NONE;
      target   = FLR_NONE;
      dir_flip = 1'b0;

      // nearest pending floor strictly above / below the car
      case (cur_floor)
         FLR1: begin
            if (pending[1])      up_t = FLR2;
            else if (pending[2]) up_t = FLR3;
         end
         FLR2: begin
            if (pending[2]) up_t = FLR3;
            if (pending[0]) dn_t = FLR1;
         end
         FLR3: begin
            if (pending[1])      dn_t = FLR2;
            else if (pending[0]) dn_t = FLR1;
         end
         default: ;
      endcase

      if ((pending & cur_floor) != FLR_NONE) begin
         target = cur_floor;
      end else if (dir_up && (up_t != FLR_NONE)) begin
         target = up_t;
      end else if (!dir_up && (dn_t != FLR_NONE)) begin
         target = dn_t;
      end else if (dir_up && (dn_t != FLR_NONE)) begin
         target   = dn_t;
         dir_flip = 1'b1;
      end else if (!dir_up && (up_t != FLR_NONE)) begin
         target   = up_t;
         dir_flip = 1'b1;
      end
   end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler for a three-floor car.
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   call_btn   : level call buttons, bit0 = floor1 .. bit2 = floor3
//   door_block : door obstruction sensor, active-high
//   atflr      : controller status, [3] door open, [2:0] one-hot floor
//   flrsw      : request bus, [3] registered door_block, [2:0] target or 000
//   pending    : latched outstanding calls
//   dir_up     : sweep direction, 1 = up
//   fault      : sticky arrival-timeout flag
// Calls are latched, one is chosen in IDLE, requested during SERVE, and the
// car is held idle for DWELL_CYCLES after arrival (restarted by door_block).
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] call_btn,
   input  logic       door_block,
   input  logic [3:0] atflr,
   output logic [3:0] flrsw,
   output logic [2:0] pending,
   output logic       dir_up,
   output logic       fault
);

   localparam int unsigned CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    target, target_d;
   logic [2:0]    pending_d;
   logic [2:0]    cur_floor;
   logic [2:0]    flr_q, flr_d;
   logic [2:0]    arrive_clr, tmo_clr;
   logic [2:0]    sel_target;
   logic          sel_flip;
   logic          dir_d, fault_d, door_q;
   logic          arrived;

   elevator_target_sel u_sel (
      .pending   (pending),
      .cur_floor (cur_floor),
      .dir_up    (dir_up),
      .target    (sel_target),
      .dir_flip  (sel_flip)
   );

   assign arrive_clr = atflr[DOOR_BIT] ? atflr[FLR_MSB:0] : FLR_NONE;
   assign arrived    = atflr[DOOR_BIT] && (atflr[FLR_MSB:0] == target);

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      target_d = target;
      dir_d    = dir_up;
      fault_d  = fault;
      tmo_clr  = FLR_NONE;

      case (state)
         IDLE: begin
            if (pending != FLR_NONE) begin
               target_d = sel_target;
               dir_d    = dir_up ^ sel_flip;
               cnt_d    = '0;
               state_d  = SERVE;
            end
         end
         SERVE: begin
            if (arrived) begin
               cnt_d   = CW'(DWELL_CYCLES);
               state_d = DWELL;
            end else if (cnt >= CW'(TIMEOUT_CYCLES - 1)) begin
               // the cycle that would bring the count to TIMEOUT_CYCLES
               fault_d = 1'b1;
               tmo_clr = target;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt != '1) begin
               cnt_d = cnt + 1'b1;
            end
         end
         DWELL: begin
            // leave on the cycle the count reaches zero
            if (door_block) begin
               cnt_d = CW'(DWELL_CYCLES);
            end else if (cnt <= CW'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // arrival/timeout clears take priority over a same-cycle call
      pending_d = (pending | call_btn) & ~arrive_clr & ~tmo_clr;

      // request bus is computed from next state so it is registered yet
      // appears the cycle after the IDLE->SERVE transition
      flr_d = (state_d == SERVE) ? target_d : FLR_NONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         target    <= FLR_NONE;
         pending   <= FLR_NONE;
         cur_floor <= FLR1;
         dir_up    <= 1'b1;
         fault     <= 1'b0;
         flr_q     <= FLR_NONE;
         door_q    <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         target  <= target_d;
         pending <= pending_d;
         dir_up  <= dir_d;
         fault   <= fault_d;
         flr_q   <= flr_d;
         door_q  <= door_block;
         if (is_onehot3(atflr[FLR_MSB:0])) cur_floor <= atflr[FLR_MSB:0];
      end
   end

   assign flrsw = {door_q, flr_q};

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler: the stimulus process pushes
// expected output snapshots tagged with a cycle number, and a monitor on the
// falling clock edge pops and compares them against the DUT outputs.
module tb_elevator_call_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] call_btn;
   logic       door_block;
   logic [3:0] atflr;
   logic [3:0] flrsw;
   logic [2:0] pending;
   logic       dir_up;
   logic       fault;

   elevator_call_scheduler #(
      .DWELL_CYCLES   (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .call_btn   (call_btn),
      .door_block (door_block),
      .atflr      (atflr),
      .flrsw      (flrsw),
      .pending    (pending),
      .dir_up     (dir_up),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [3:0] M_FL  = 4'b0001;
   localparam logic [3:0] M_PE  = 4'b0010;
   localparam logic [3:0] M_DU  = 4'b0100;
   localparam logic [3:0] M_FT  = 4'b1000;
   localparam logic [3:0] M_ALL = 4'b1111;

   typedef struct {
      int unsigned at;
      string       name;
      logic [3:0]  mask;
      logic [3:0]  fl;
      logic [2:0]  pe;
      logic        du;
      logic        ft;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic expect_at(input int unsigned k, input string name, input logic [3:0] mask,
                            input logic [3:0] fl, input logic [2:0] pe, input logic du, input logic ft);
      exp_t e;
      e.at = cyc + k; e.name = name; e.mask = mask;
      e.fl = fl; e.pe = pe; e.du = du; e.ft = ft;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [3:0] mask,
                      input logic [3:0] fl, input logic [2:0] pe, input logic du, input logic ft);
      expect_at(0, name, mask, fl, pe, du, ft);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor
   exp_t m;
   logic bad;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].at <= cyc) begin
         m = q.pop_front();
         checks++;
         bad = (m.at != cyc)
            || (m.mask[0] && (flrsw   !== m.fl))
            || (m.mask[1] && (pending !== m.pe))
            || (m.mask[2] && (dir_up  !== m.du))
            || (m.mask[3] && (fault   !== m.ft));
         if (bad) begin
            errors++;
            $display("FAIL %s cyc=%0d: got flrsw=%b pending=%b dir_up=%b fault=%b, want flrsw=%b pending=%b dir_up=%b fault=%b (mask %b, due cyc %0d)",
                     m.name, cyc, flrsw, pending, dir_up, fault, m.fl, m.pe, m.du, m.ft, m.mask, m.at);
         end
      end
   end

   initial begin
      // reset with calls held: they must be discarded
      rst_n = 1'b0; call_btn = 3'b111; door_block = 1'b0; atflr = 4'b0000;
      repeat (3) tick();
      chk("reset", M_ALL, 4'b0000, 3'b000, 1'b1, 1'b0);
      rst_n = 1'b1; call_btn = 3'b000;
      tick();
      chk("reset_calls_dropped", M_FL | M_PE, 4'b0000, 3'b000, 1'b0, 1'b0);

      // single call to floor3 from floor1
      atflr = 4'b0001; call_btn = 3'b100;
      expect_at(1, "t1_pending", M_FL | M_PE, 4'b0000, 3'b100, 1'b0, 1'b0);
      expect_at(2, "t1_serve", M_FL | M_DU, 4'b0100, 3'b100, 1'b1, 1'b0);
      tick();
      call_btn = 3'b000;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_hold", M_FL | M_PE, 4'b0100, 3'b100, 1'b0, 1'b0);
      end
      atflr = 4'b1100;
      tick();
      chk("t1_arrive", M_FL | M_PE, 4'b0000, 3'b000, 1'b0, 1'b0);
      atflr = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_dwell", M_FL, 4'b0000, 3'b000, 1'b0, 1'b0);
      end
      tick();
      chk("t1_idle", M_ALL, 4'b0000, 3'b000, 1'b1, 1'b0);

      // car at floor2 going up, calls at 1 and 3: floor3 first, then reverse
      atflr = 4'b0010; call_btn = 3'b101;
      tick();
      chk("t2_latch", M_FL | M_PE, 4'b0000, 3'b101, 1'b0, 1'b0);
      call_btn = 3'b000;
      tick();
      chk("t2_up_first", M_ALL, 4'b0100, 3'b101, 1'b1, 1'b0);
      tick();
      atflr = 4'b1100;
      tick();
      chk("t2_arrive3", M_FL | M_PE, 4'b0000, 3'b001, 1'b0, 1'b0);
      atflr = 4'b0100;
      repeat (3) tick();
      tick();
      chk("t2_idle", M_FL, 4'b0000, 3'b000, 1'b0, 1'b0);
      tick();
      chk("t2_reverse", M_ALL, 4'b0001, 3'b001, 1'b0, 1'b0);
      atflr = 4'b1001;
      tick();
      chk("t2_arrive1", M_FL | M_PE, 4'b0000, 3'b000, 1'b0, 1'b0);
      atflr = 4'b0001;
      repeat (4) tick();

      // arrival clear beats a same-cycle call
      atflr = 4'b1001; call_btn = 3'b001;
      tick();
      chk("t3_clear_wins", M_FL | M_PE, 4'b0000, 3'b000, 1'b0, 1'b0);
      atflr = 4'b0001; call_btn = 3'b000;
      tick();
      chk("t3_stay_idle", M_ALL, 4'b0000, 3'b000, 1'b0, 1'b0);

      // door_block during dwell restarts the dwell count
      call_btn = 3'b010;
      tick();
      chk("t4_latch", M_PE, 4'b0000, 3'b010, 1'b0, 1'b0);
      call_btn = 3'b000;
      tick();
      chk("t4_serve2", M_ALL, 4'b0010, 3'b010, 1'b1, 1'b0);
      atflr = 4'b1010;
      tick();
      chk("t4_arrive", M_FL | M_PE, 4'b0000, 3'b000, 1'b0, 1'b0);
      atflr = 4'b0010;
      repeat (3) tick();
      door_block = 1'b1;
      tick();
      chk("t4_door_reg", M_FL, 4'b1000, 3'b000, 1'b0, 1'b0);
      door_block = 1'b0;
      tick();
      chk("t4_door_low", M_FL, 4'b0000, 3'b000, 1'b0, 1'b0);
      call_btn = 3'b100;
      tick();
      call_btn = 3'b000;
      tick();
      chk("t4_still_dwell", M_FL | M_PE, 4'b0000, 3'b100, 1'b0, 1'b0);
      tick();
      chk("t4_idle", M_FL, 4'b0000, 3'b000, 1'b0, 1'b0);
      tick();
      chk("t5_serve3", M_ALL, 4'b0100, 3'b100, 1'b1, 1'b0);

      // floor3 never reached: timeout; a call during SERVE keeps the target
      for (int s = 1; s <= 15; s++) begin
         tick();
         call_btn = (s == 2) ? 3'b001 : 3'b000;
         chk("t5_wait", M_ALL, 4'b0100, (s >= 3) ? 3'b101 : 3'b100, 1'b1, 1'b0);
      end
      tick();
      chk("t5_timeout", M_ALL, 4'b0000, 3'b001, 1'b1, 1'b1);
      tick();
      chk("t5_next_call", M_ALL, 4'b0001, 3'b001, 1'b0, 1'b1);
      call_btn = 3'b110;
      tick();
      chk("t6_pend_all", M_ALL, 4'b0001, 3'b111, 1'b0, 1'b1);

      // reset mid-SERVE
      rst_n = 1'b0; call_btn = 3'b111;
      tick();
      chk("t6_reset", M_ALL, 4'b0000, 3'b000, 1'b1, 1'b0);
      rst_n = 1'b1; call_btn = 3'b000;
      tick();
      chk("t6_after_reset", M_ALL, 4'b0000, 3'b000, 1'b1, 1'b0);

      tick();
      tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/elevator_call_scheduler.md
ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, idle cycles held after each arrival so the door can close.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles from request to arrival before fault.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 call_btn  input  3  hall/car call buttons, bit0=floor1, bit1=floor2, bit2=floor3; level, sampled every cycle.
REQ-006 door_block  input  1  door obstruction sensor, active-high.
REQ-007 atflr  input  4  car status from the elevator controller; bit3=door open, bits[2:0] one-hot floor.
REQ-008 flrsw  output  4  request bus to the elevator controller; bit3=door block, bits[2:0] one-hot target floor or 000.
REQ-009 pending  output  3  latched outstanding calls, same bit mapping as call_btn.
REQ-010 dir_up  output  1  current sweep direction, 1=up.
REQ-011 fault  output  1  sticky arrival-timeout flag.

Function
REQ-012 pending[i] SHALL set on the cycle after call_btn[i]=1 and clear on the cycle after atflr[3]=1 with atflr[i]=1; clear wins over set in the same cycle.
REQ-013 cur_floor SHALL load atflr[2:0] whenever it is exactly one-hot; other values leave it unchanged.
REQ-014 FSM states SHALL be IDLE, SERVE, DWELL.
REQ-015 IDLE: when pending is non-zero, latch target from the selector, reload the timeout counter, go to SERVE; otherwise stay.
REQ-016 Selector priority: pending at cur_floor first; else nearest pending floor in dir_up direction; else nearest in the opposite direction, with dir_up toggled in the same cycle.
REQ-017 SERVE: flrsw[2:0] SHALL equal target one-hot on every cycle in SERVE, starting the cycle after the IDLE->SERVE transition.
REQ-018 SERVE->DWELL SHALL occur when atflr[3]=1 and atflr equals target in bits[2:0]; the dwell counter is loaded with DWELL_CYCLES.
REQ-019 SERVE timeout: when the counter reaches TIMEOUT_CYCLES without arrival, set fault, clear pending[target], and go to IDLE.
REQ-020 DWELL: flrsw[2:0]=000; counter decrements each cycle; door_block=1 reloads it to DWELL_CYCLES; counter 0 -> IDLE.
REQ-021 flrsw[3] SHALL be door_block registered one cycle, in every state.
REQ-022 flrsw[2:0] SHALL never have more than one bit set.
REQ-023 A new call arriving during SERVE SHALL NOT change target; it is served on a later IDLE pass.
REQ-024 Counters SHALL be sized to hold max(DWELL_CYCLES, TIMEOUT_CYCLES) without wrap; they saturate rather than wrap.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst_n=0 on a rising edge SHALL force IDLE, flrsw=0000, pending=000, dir_up=1, fault=0, cur_floor=001, counters=0, regardless of state.
REQ-027 Calls asserted while rst_n=0 SHALL be discarded.

Structure
REQ-028 Floor one-hot constants, atflr/flrsw bit positions and the FSM state enum SHALL live in shared package elevator_pkg.
REQ-029 Target selection (REQ-016) SHALL be a combinational sub-module elevator_target_sel (inputs pending, cur_floor, dir_up; outputs target, dir_flip).

Verification
REQ-030 Reset, then call_btn=100 for 1 cycle at floor1 -> pending=100 next cycle, flrsw=0100 one cycle later, held until atflr=1100, then flrsw=0000 for 4 cycles, pending=000.
REQ-031 Car at floor2, dir_up=1, pending=101 -> target floor3 first (flrsw=0100); after dwell, dir_up=0 and flrsw=0001.
REQ-032 atflr=1001 with call_btn=001 in same cycle -> pending[0] stays 0 (clear wins), FSM stays IDLE.
REQ-033 SERVE with target floor3, atflr never reaches 1100 -> fault=1 at cycle 16, pending[2]=0, FSM IDLE; fault remains 1 until rst_n=0.
REQ-034 DWELL with door_block pulsed high at dwell count 1 -> flrsw=1000 the next cycle, dwell restarts at 4, IDLE entered 4 cycles after door_block falls.
REQ-035 rst_n=0 mid-SERVE with pending=111 -> next cycle flrsw=0000, pending=000, dir_up=1, fault=0.
